// File: rtl/rvc_compressor_packer.sv
// rvc_compressor_packer
//   Streaming RV32I -> RVC compressor and fetch-word packer. Each accepted
//   32-bit instruction is replaced by its exact 16-bit RVC encoding when one
//   exists, otherwise passed through unchanged. The resulting 16/32-bit
//   parcels are packed little-endian into 32-bit words. This is the layout
//   the core's fetch/decompress path consumes.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid_i       in_instr_i is valid
//   in_ready_o       input accepted this cycle (= !out_valid_o || out_ready_i)
//   in_instr_i[31:0] RV32I instruction
//   flush_i          level request: emit a held halfword padded with c.nop
//   out_valid_o      out_word_o is valid
//   out_ready_i      consumer takes out_word_o
//   out_word_o[31:0] packed word, bits [15:0] hold the earlier parcel
//   held_o           a 16-bit parcel is pending in the hold register
//   comp_count_o     saturating count of compressed instructions
module rvc_compressor_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_word_o,
  output logic        held_o,
  output logic [15:0] comp_count_o
);

  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [31:0] EBREAK     = 32'h00100073;
  localparam logic [15:0] C_NOP      = 16'h0001;

  typedef enum logic [3:0] {
    K_NONE,
    K_EBREAK,
    K_LI,
    K_ADDI,
    K_SLLI,
    K_MV,
    K_ADD,
    K_ALU,
    K_JR,
    K_JALR,
    K_LWSP,
    K_SWSP,
    K_LW,
    K_SW
  } kind_e;

  // ---------------------------------------------------------------------------
  // Instruction field extraction
  // ---------------------------------------------------------------------------
  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic        imm6_ok;
  logic        rd_c;
  logic        rs1_c;
  logic        rs2_c;

  assign opc   = in_instr_i[6:0];
  assign rd    = in_instr_i[11:7];
  assign f3    = in_instr_i[14:12];
  assign rs1   = in_instr_i[19:15];
  assign rs2   = in_instr_i[24:20];
  assign f7    = in_instr_i[31:25];
  assign imm_i = in_instr_i[31:20];
  assign imm_s = {in_instr_i[31:25], in_instr_i[11:7]};

  // I-immediate fits the 6-bit signed RVC field: bits [11:5] all equal bit 5.
  assign imm6_ok = (imm_i[11:5] == {7{imm_i[5]}});
  // Register lies in the compressed set x8..x15.
  assign rd_c  = (rd[4:3]  == 2'b01);
  assign rs1_c = (rs1[4:3] == 2'b01);
  assign rs2_c = (rs2[4:3] == 2'b01);

  // ---------------------------------------------------------------------------
  // Rule selection, in priority order
  // ---------------------------------------------------------------------------
  kind_e      kind;
  logic [1:0] alu_f2;

  always_comb begin
    kind   = K_NONE;
    alu_f2 = 2'b00;
    if (in_instr_i == EBREAK) begin
      kind = K_EBREAK;
    end else if (opc == OPC_OP_IMM && f3 == 3'b000 && rs1 == 5'd0 &&
                 rd != 5'd0 && imm6_ok) begin
      kind = K_LI;
    end else if (opc == OPC_OP_IMM && f3 == 3'b000 && rs1 == rd &&
                 rd != 5'd0 && imm_i != 12'd0 && imm6_ok) begin
      kind = K_ADDI;
    end else if (opc == OPC_OP_IMM && f3 == 3'b001 && f7 == 7'd0 &&
                 rs1 == rd && rd != 5'd0 && rs2 != 5'd0) begin
      kind = K_SLLI;
    end else if (opc == OPC_OP && f3 == 3'b000 && f7 == 7'd0 &&
                 rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0) begin
      kind = K_MV;
    end else if (opc == OPC_OP && f3 == 3'b000 && f7 == 7'd0 &&
                 rs1 == rd && rd != 5'd0 && rs2 != 5'd0) begin
      kind = K_ADD;
    end else if (opc == OPC_OP && rs1 == rd && rd_c && rs2_c &&
                 ((f7 == 7'h20 && f3 == 3'b000) ||
                  (f7 == 7'h00 && (f3 == 3'b100 || f3 == 3'b110 || f3 == 3'b111)))) begin
      kind = K_ALU;
      unique case (f3)
        3'b100:  alu_f2 = 2'b01;
        3'b110:  alu_f2 = 2'b10;
        3'b111:  alu_f2 = 2'b11;
        default: alu_f2 = 2'b00;
      endcase
    end else if (opc == OPC_JALR && f3 == 3'b000 && imm_i == 12'd0 &&
                 rd == 5'd0 && rs1 != 5'd0) begin
      kind = K_JR;
    end else if (opc == OPC_JALR && f3 == 3'b000 && imm_i == 12'd0 &&
                 rd == 5'd1 && rs1 != 5'd0) begin
      kind = K_JALR;
    end else if (opc == OPC_LOAD && f3 == 3'b010 && rs1 == 5'd2 && rd != 5'd0 &&
                 imm_i[11:8] == 4'd0 && imm_i[1:0] == 2'b00) begin
      kind = K_LWSP;
    end else if (opc == OPC_STORE && f3 == 3'b010 && rs1 == 5'd2 &&
                 imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'b00) begin
      kind = K_SWSP;
    end else if (opc == OPC_LOAD && f3 == 3'b010 && rs1_c && rd_c &&
                 imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00) begin
      kind = K_LW;
    end else if (opc == OPC_STORE && f3 == 3'b010 && rs1_c && rs2_c &&
                 imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'b00) begin
      kind = K_SW;
    end
  end

  // ---------------------------------------------------------------------------
  // RVC encoding of the selected rule
  // ---------------------------------------------------------------------------
  logic        is_c;
  logic [15:0] parcel;

  always_comb begin
    is_c   = (kind != K_NONE);
    parcel = '0;
    unique case (kind)
      K_EBREAK: parcel = 16'h9002;
      K_LI:     parcel = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
      K_ADDI:   parcel = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
      K_SLLI:   parcel = {3'b000, 1'b0, rd, rs2, 2'b10};
      K_MV:     parcel = {4'b1000, rd, rs2, 2'b10};
      K_ADD:    parcel = {4'b1001, rd, rs2, 2'b10};
      K_ALU:    parcel = {6'b100011, rd[2:0], alu_f2, rs2[2:0], 2'b01};
      K_JR:     parcel = {4'b1000, rs1, 5'd0, 2'b10};
      K_JALR:   parcel = {4'b1001, rs1, 5'd0, 2'b10};
      K_LWSP:   parcel = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
      K_SWSP:   parcel = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
      K_LW:     parcel = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
      K_SW:     parcel = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
      default:  parcel = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packing state and one-deep output register
  // ---------------------------------------------------------------------------
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_word_q,  out_word_d;
  logic [15:0] hold_q,      hold_d;
  logic        held_q,      held_d;
  logic [15:0] comp_count_q, comp_count_d;
  logic        accept;
  logic        flush_go;

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  // Flush only acts in an input-idle cycle with a free output slot; a flush
  // raised alongside in_valid_i simply stays pending.
  assign flush_go   = flush_i && !in_valid_i && held_q && in_ready_o;

  always_comb begin
    out_valid_d  = out_valid_q && !out_ready_i;
    out_word_d   = out_word_q;
    hold_d       = hold_q;
    held_d       = held_q;
    comp_count_d = comp_count_q;
    if (accept) begin
      if (is_c) begin
        if (comp_count_q != '1) begin
          comp_count_d = comp_count_q + 16'd1;
        end
        if (held_q) begin
          out_valid_d = 1'b1;
          out_word_d  = {parcel, hold_q};
          held_d      = 1'b0;
        end else begin
          hold_d = parcel;
          held_d = 1'b1;
        end
      end else if (held_q) begin
        // 32-bit instruction straddles: low half completes this word, high
        // half becomes the new pending parcel.
        out_valid_d = 1'b1;
        out_word_d  = {in_instr_i[15:0], hold_q};
        hold_d      = in_instr_i[31:16];
      end else begin
        out_valid_d = 1'b1;
        out_word_d  = in_instr_i;
      end
    end else if (flush_go) begin
      out_valid_d = 1'b1;
      out_word_d  = {C_NOP, hold_q};
      held_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      hold_q       <= '0;
      held_q       <= 1'b0;
      comp_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      hold_q       <= hold_d;
      held_q       <= held_d;
      comp_count_q <= comp_count_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_word_o   = out_word_q;
  assign held_o       = held_q;
  assign comp_count_o = comp_count_q;

endmodule

// File: tb/tb_rvc_compressor_packer.sv
// tb_rvc_compressor_packer
//   Directed vectors with hand-computed packed words, reset/backpressure
//   checks, and a random stream rebuilt through an independent RVC expander.
module tb_rvc_compressor_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        held;
  logic [15:0] comp_count;

  rvc_compressor_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_instr_i   (in_instr),
    .flush_i      (flush),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_word_o   (out_word),
    .held_o       (held),
    .comp_count_o (comp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins;
    logic        c;
  } exp_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] got_q[$];
  exp_t        exp_q[$];

  // Record every transferred word; sampled mid-cycle, the transfer happens at
  // the following rising edge.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) got_q.push_back(out_word);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] ins, input bit rnd);
    int unsigned n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic gap(input int unsigned n, input logic fl);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      flush     = fl;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic do_flush();
    int unsigned n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    #1;
    while (held && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    flush = 1'b0;
    check("flush_held", {31'd0, held}, 32'd0);
  endtask

  task automatic check_next(input string tag, input logic [31:0] exp);
    int unsigned n;
    n = 0;
    while (got_q.size() == 0 && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (got_q.size() == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    else check(tag, got_q.pop_front(), exp);
  endtask

  // Independent RVC -> RV32I expander for the subset the packer emits.
  function automatic logic [31:0] expand(input logic [15:0] h);
    logic [4:0]  rd;
    logic [4:0]  r2;
    logic [4:0]  r_hi;
    logic [4:0]  r_lo;
    logic [11:0] imm;
    logic [31:0] r;
    rd   = h[11:7];
    r2   = h[6:2];
    r_hi = {2'b01, h[9:7]};
    r_lo = {2'b01, h[4:2]};
    imm  = {{6{h[12]}}, h[12], h[6:2]};
    r    = 32'hDEADBEEF;
    if (h == 16'h9002) begin
      r = 32'h00100073;
    end else begin
      case ({h[1:0], h[15:13]})
        5'b01_010: r = {imm, 5'd0, 3'd0, rd, 7'h13};
        5'b01_000: r = {imm, rd, 3'd0, rd, 7'h13};
        5'b01_100: if (h[12:10] == 3'b011) begin
          case (h[6:5])
            2'b00:   r = {7'h20, r_lo, r_hi, 3'd0, r_hi, 7'h33};
            2'b01:   r = {7'h00, r_lo, r_hi, 3'd4, r_hi, 7'h33};
            2'b10:   r = {7'h00, r_lo, r_hi, 3'd6, r_hi, 7'h33};
            default: r = {7'h00, r_lo, r_hi, 3'd7, r_hi, 7'h33};
          endcase
        end
        5'b10_000: if (!h[12]) r = {7'd0, r2, rd, 3'd1, rd, 7'h13};
        5'b10_010: r = {4'd0, h[3:2], h[12], h[6:4], 2'b00, 5'd2, 3'd2, rd, 7'h03};
        5'b10_110: begin
          imm = {4'd0, h[8:7], h[12:9], 2'b00};
          r   = {imm[11:5], r2, 5'd2, 3'd2, imm[4:0], 7'h23};
        end
        5'b10_100: begin
          if (!h[12]) r = (r2 == 5'd0) ? {12'd0, rd, 3'd0, 5'd0, 7'h67}
                                       : {7'd0, r2, 5'd0, 3'd0, rd, 7'h33};
          else        r = (r2 == 5'd0) ? {12'd0, rd, 3'd0, 5'd1, 7'h67}
                                       : {7'd0, r2, rd, 3'd0, rd, 7'h33};
        end
        5'b00_010: begin
          imm = {5'd0, h[5], h[12:10], h[6], 2'b00};
          r   = {imm, r_hi, 3'd2, r_lo, 7'h03};
        end
        5'b00_110: begin
          imm = {5'd0, h[5], h[12:10], h[6], 2'b00};
          r   = {imm[11:5], r_lo, r_hi, 3'd2, imm[4:0], 7'h23};
        end
        default: r = 32'hDEADBEEF;
      endcase
    end
    return r;
  endfunction

  // Random instruction from a template whose compressibility is known.
  task automatic gen(output logic [31:0] ins, output logic c);
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rh;
    logic [5:0]  b6;
    logic [11:0] imm;
    logic [31:0] r;
    int unsigned v;
    rd  = 5'($urandom_range(1, 31));
    rs  = 5'($urandom_range(1, 31));
    b6  = 6'($urandom_range(0, 63));
    r   = $urandom;
    c   = 1'b1;
    ins = 32'h0;
    case ($urandom_range(0, 15))
      0:  ins = 32'h00100073;
      1:  ins = {{6{b6[5]}}, b6, 5'd0, 3'd0, rd, 7'h13};
      2:  begin
        if (b6 == 6'd0) b6 = 6'd1;
        ins = {{6{b6[5]}}, b6, rd, 3'd0, rd, 7'h13};
      end
      3:  ins = {7'd0, rs, rd, 3'd1, rd, 7'h13};
      4:  ins = {7'd0, rs, 5'd0, 3'd0, rd, 7'h33};
      5:  ins = {7'd0, rs, rd, 3'd0, rd, 7'h33};
      6:  begin
        rd = {2'b01, rd[2:0]};
        rs = {2'b01, rs[2:0]};
        case ($urandom_range(0, 3))
          0:       ins = {7'h20, rs, rd, 3'd0, rd, 7'h33};
          1:       ins = {7'h00, rs, rd, 3'd4, rd, 7'h33};
          2:       ins = {7'h00, rs, rd, 3'd6, rd, 7'h33};
          default: ins = {7'h00, rs, rd, 3'd7, rd, 7'h33};
        endcase
      end
      7:  ins = {12'd0, rs, 3'd0, 5'($urandom_range(0, 1)), 7'h67};
      8:  begin
        imm = {4'd0, b6, 2'b00};
        if (r[0]) ins = {imm, 5'd2, 3'd2, rd, 7'h03};
        else      ins = {imm[11:5], 5'($urandom_range(0, 31)), 5'd2, 3'd2, imm[4:0], 7'h23};
      end
      9:  begin
        imm = {5'd0, b6[4:0], 2'b00};
        if (r[0]) ins = {imm, 2'b01, rs[2:0], 3'd2, 2'b01, rd[2:0], 7'h03};
        else      ins = {imm[11:5], 2'b01, rd[2:0], 2'b01, rs[2:0], 3'd2, imm[4:0], 7'h23};
      end
      10: begin c = 1'b0; ins = {r[31:12], rd, 7'h37}; end
      11: begin
        c   = 1'b0;
        v   = $urandom_range(32, 2047);
        imm = r[0] ? 12'(-(v + 1)) : 12'(v);
        ins = {imm, rd, 3'd0, rd, 7'h13};
      end
      12: begin
        c   = 1'b0;
        imm = {4'd0, 1'b1, b6[4:0], 2'b00};
        ins = {imm, 2'b01, rs[2:0], 3'd2, 2'b01, rd[2:0], 7'h03};
      end
      13: begin
        c   = 1'b0;
        ins = {12'($urandom_range(1, 4095)), rs, 3'd0, 5'($urandom_range(0, 1)), 7'h67};
      end
      14: begin
        c   = 1'b0;
        rh  = {1'b1, rd[3:0]};
        ins = {7'h20, rs, rh, 3'd0, rh, 7'h33};
      end
      default: begin c = 1'b0; ins = {r[31:7], 7'h63}; end
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic        c;
    logic [15:0] hw[$];
    logic [31:0] w;
    logic [31:0] dec;
    logic        is16;
    exp_t        e;
    int unsigned ncomp;
    int unsigned idx;
    int unsigned n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    check("rst_out_word",   out_word, 32'd0);
    check("rst_held",       {31'd0, held}, 32'd0);
    check("rst_comp_count", {16'd0, comp_count}, 32'd0);
    check("rst_in_ready",   {31'd0, in_ready}, 32'd1);

    // Asynchronous reset with a stalled word and a pending halfword.
    out_ready = 1'b0;
    send(32'h00500513, 1'b0);
    send(32'h123452B7, 1'b0);
    @(negedge clk);
    #1;
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_held",      {31'd0, held}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid",  {31'd0, out_valid}, 32'd0);
    check("arst_out_word",   out_word, 32'd0);
    check("arst_held",       {31'd0, held}, 32'd0);
    check("arst_comp_count", {16'd0, comp_count}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);

    // Pair of c.li
    send(32'h00500513, 1'b0);
    send(32'hFFF00593, 1'b0);
    check_next("pair_word", 32'h55FD4515);
    @(negedge clk);
    #1;
    check("pair_count", {16'd0, comp_count}, 32'd2);
    check("pair_held",  {31'd0, held}, 32'd0);

    // Straddle then flush
    send(32'h00500513, 1'b0);
    send(32'h123452B7, 1'b0);
    check_next("straddle_word", 32'h52B74515);
    do_flush();
    check_next("straddle_flush", 32'h00011234);

    // Immediate / offset boundaries
    send(32'h02050513, 1'b0);
    check_next("addi_32_pass", 32'h02050513);
    send(32'hFE050513, 1'b0);
    send(32'h08042483, 1'b0);
    check_next("addi_m32_lw128", 32'h24831501);
    do_flush();
    check_next("lw128_flush", 32'h00010804);

    // c.ebreak + c.mv, c.lw + c.jr, c.sub + c.lwsp, then pass-throughs
    send(32'h00100073, 1'b0);
    send(32'h002000B3, 1'b0);
    check_next("ebreak_mv", 32'h808A9002);
    send(32'h07C42483, 1'b0);
    send(32'h00008067, 1'b0);
    check_next("lw124_jr", 32'h80825C64);
    send(32'h40940433, 1'b0);
    send(32'h00812503, 1'b0);
    check_next("sub_lwsp", 32'h45228C05);
    send(32'h00812003, 1'b0);
    check_next("lwsp_x0_pass", 32'h00812003);
    send(32'h12345670, 1'b0);
    check_next("quad0_pass", 32'h12345670);
    @(negedge clk);
    #1;
    check("directed_count", {16'd0, comp_count}, 32'd10);

    // Backpressure: stalled output, input held valid for 5 cycles
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h02050513, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = 32'h12345670;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_word",     out_word, 32'h02050513);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_next("bp_first",  32'h02050513);
    check_next("bp_second", 32'h12345670);

    // Random stream with random backpressure, gaps and mid-stream flushes
    ncomp = 0;
    for (int i = 0; i < 1500; i++) begin
      gen(ins, c);
      exp_q.push_back('{ins: ins, c: c});
      if (c) ncomp++;
      if ($urandom_range(0, 9) == 0) gap($urandom_range(1, 3), 1'($urandom_range(0, 1)));
      send(ins, 1'b1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    do_flush();
    n = 0;
    #1;
    while (out_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #3;

    while (got_q.size() > 0) begin
      w = got_q.pop_front();
      hw.push_back(w[15:0]);
      hw.push_back(w[31:16]);
    end
    idx = 0;
    while (idx < hw.size()) begin
      if (hw[idx] == 16'h0001) begin
        idx++;
        continue;
      end
      if (hw[idx][1:0] != 2'b11) begin
        dec  = expand(hw[idx]);
        is16 = 1'b1;
        idx++;
      end else if (idx + 1 < hw.size()) begin
        dec  = {hw[idx + 1], hw[idx]};
        is16 = 1'b0;
        idx += 2;
      end else begin
        check("rnd_truncated", 32'd1, 32'd0);
        break;
      end
      if (exp_q.size() == 0) begin
        check("rnd_extra_parcel", 32'd1, 32'd0);
        break;
      end
      e = exp_q.pop_front();
      check("rnd_instr", dec, e.ins);
      check("rnd_size16", {31'd0, is16}, {31'd0, e.c});
    end
    check("rnd_missing", exp_q.size(), 32'd0);
    check("rnd_comp_count", {16'd0, comp_count}, 32'(10 + ncomp));
    check("rnd_held_end", {31'd0, held}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
